// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter sharing one slave port. Losing requests are
// parked in a per-master pending register and issued later.
// Optional build macro: AHB_ARB_RR_EN selects round-robin instead of M0 priority.
module ahb_lite_arb2 #(
    parameter int HADDR_WIDTH = 17,
    parameter int HDATA_WIDTH = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [HADDR_WIDTH-1:0] M0_HADDR,
    input  logic [1:0]             M0_HTRANS,
    input  logic [2:0]             M0_HSIZE,
    input  logic                   M0_HWRITE,
    input  logic [HDATA_WIDTH-1:0] M0_HWDATA,
    output logic [HDATA_WIDTH-1:0] M0_HRDATA,
    output logic                   M0_HREADY,
    output logic                   M0_HRESP,
    input  logic [HADDR_WIDTH-1:0] M1_HADDR,
    input  logic [1:0]             M1_HTRANS,
    input  logic [2:0]             M1_HSIZE,
    input  logic                   M1_HWRITE,
    input  logic [HDATA_WIDTH-1:0] M1_HWDATA,
    output logic [HDATA_WIDTH-1:0] M1_HRDATA,
    output logic                   M1_HREADY,
    output logic                   M1_HRESP,
    output logic [HADDR_WIDTH-1:0] S_HADDR,
    output logic [1:0]             S_HTRANS,
    output logic [2:0]             S_HSIZE,
    output logic                   S_HWRITE,
    output logic [HDATA_WIDTH-1:0] S_HWDATA,
    output logic                   S_HSEL,
    output logic                   S_HREADY,
    input  logic [HDATA_WIDTH-1:0] S_HRDATA,
    input  logic                   S_HREADYOUT,
    input  logic                   S_HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    logic                   pend0_v, pend1_v;
    logic [HADDR_WIDTH-1:0] pend0_addr, pend1_addr;
    logic [2:0]             pend0_size, pend1_size;
    logic                   pend0_write, pend1_write;
    logic                   dp_valid;
    logic                   dp_owner;

    logic live0, live1, req0, req1, pick1, arb_en, gnt0, gnt1, grant;

    // Handshake: a master's address phase is accepted in any cycle where its
    // HREADY is 1; the arbiter either forwards it or parks it in pend_x and
    // then holds that master's HREADY low until the parked transfer finishes.
    assign M0_HREADY = pend0_v ? 1'b0 : ((dp_valid && !dp_owner) ? S_HREADYOUT : 1'b1);
    assign M1_HREADY = pend1_v ? 1'b0 : ((dp_valid &&  dp_owner) ? S_HREADYOUT : 1'b1);

    assign live0 = (M0_HTRANS == HTRANS_NONSEQ || M0_HTRANS == HTRANS_SEQ) && M0_HREADY;
    assign live1 = (M1_HTRANS == HTRANS_NONSEQ || M1_HTRANS == HTRANS_SEQ) && M1_HREADY;
    assign req0  = pend0_v | live0;
    assign req1  = pend1_v | live1;

`ifdef AHB_ARB_RR_EN
    logic rr_last;

    // rr_last=1 means M1 was granted last, so M0 takes the next contended slot.
    assign pick1 = req1 & (~req0 | ~rr_last);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_last <= 1'b1;
        end else if (grant) begin
            rr_last <= gnt1;
        end
    end
`else
    assign pick1 = req1 & ~req0;
`endif

    assign arb_en = S_HREADYOUT & ~HRESET;
    assign gnt0   = arb_en & req0 & ~pick1;
    assign gnt1   = arb_en & pick1;
    assign grant  = gnt0 | gnt1;

    always_comb begin
        S_HADDR  = M0_HADDR;
        S_HSIZE  = M0_HSIZE;
        S_HWRITE = M0_HWRITE;
        S_HTRANS = HTRANS_IDLE;
        S_HSEL   = 1'b0;
        if (gnt0) begin
            S_HADDR  = pend0_v ? pend0_addr  : M0_HADDR;
            S_HSIZE  = pend0_v ? pend0_size  : M0_HSIZE;
            S_HWRITE = pend0_v ? pend0_write : M0_HWRITE;
            S_HTRANS = HTRANS_NONSEQ;
            S_HSEL   = 1'b1;
        end else if (gnt1) begin
            S_HADDR  = pend1_v ? pend1_addr  : M1_HADDR;
            S_HSIZE  = pend1_v ? pend1_size  : M1_HSIZE;
            S_HWRITE = pend1_v ? pend1_write : M1_HWRITE;
            S_HTRANS = HTRANS_NONSEQ;
            S_HSEL   = 1'b1;
        end
    end

    assign S_HWDATA  = (dp_valid && dp_owner) ? M1_HWDATA : M0_HWDATA;
    assign S_HREADY  = S_HREADYOUT;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign M0_HRESP  = (dp_valid && !dp_owner) ? S_HRESP : 1'b0;
    assign M1_HRESP  = (dp_valid &&  dp_owner) ? S_HRESP : 1'b0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend0_v     <= 1'b0;
            pend1_v     <= 1'b0;
            pend0_addr  <= '0;
            pend1_addr  <= '0;
            pend0_size  <= '0;
            pend1_size  <= '0;
            pend0_write <= 1'b0;
            pend1_write <= 1'b0;
            dp_valid    <= 1'b0;
            dp_owner    <= 1'b0;
        end else begin
            if (live0 && !gnt0) begin
                pend0_v     <= 1'b1;
                pend0_addr  <= M0_HADDR;
                pend0_size  <= M0_HSIZE;
                pend0_write <= M0_HWRITE;
            end else if (gnt0) begin
                pend0_v <= 1'b0;
            end
            if (live1 && !gnt1) begin
                pend1_v     <= 1'b1;
                pend1_addr  <= M1_HADDR;
                pend1_size  <= M1_HSIZE;
                pend1_write <= M1_HWRITE;
            end else if (gnt1) begin
                pend1_v <= 1'b0;
            end
            // Data phase advances only while the slave is ready.
            if (S_HREADYOUT) begin
                dp_valid <= grant;
                if (grant) begin
                    dp_owner <= gnt1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Self-checking bench for ahb_lite_arb2: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_ahb_lite_arb2;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [AW-1:0] M0_HADDR, M1_HADDR;
  logic [1:0]    M0_HTRANS, M1_HTRANS;
  logic [2:0]    M0_HSIZE, M1_HSIZE;
  logic          M0_HWRITE, M1_HWRITE;
  logic [DW-1:0] M0_HWDATA, M1_HWDATA;
  logic [DW-1:0] M0_HRDATA, M1_HRDATA;
  logic          M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [AW-1:0] S_HADDR;
  logic [1:0]    S_HTRANS;
  logic [2:0]    S_HSIZE;
  logic          S_HWRITE, S_HSEL, S_HREADY;
  logic [DW-1:0] S_HWDATA, S_HRDATA;
  logic          S_HREADYOUT, S_HRESP;

  int n_pass = 0;
  int n_total = 0;

  ahb_lite_arb2 #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE), .S_HWRITE(S_HWRITE),
    .S_HWDATA(S_HWDATA), .S_HSEL(S_HSEL), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    M0_HADDR = '0; M0_HTRANS = ID; M0_HSIZE = 3'b010; M0_HWRITE = 1'b0; M0_HWDATA = '0;
    M1_HADDR = '0; M1_HTRANS = ID; M1_HSIZE = 3'b010; M1_HWRITE = 1'b0; M1_HWDATA = '0;
    S_HRDATA = '0; S_HREADYOUT = 1'b1; S_HRESP = 1'b0;
  endtask

  // behavioural reference: which requests are waiting, who owns the data phase
  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic          wr;
  } req_t;

  logic waiting [2];
  req_t held    [2];
  int   dp_own;      // -1: no transfer in data phase
  int   last_win;
  logic prev_rdy [2];

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      waiting[x] = 1'b0;
      prev_rdy[x] = 1'b1;
    end
    dp_own = -1;
    last_win = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    model_reset();
  endtask

  // Called at the negedge: predicts, compares, then advances the model.
  task automatic model_cycle();
    logic       e_rdy [2];
    logic       live  [2];
    logic       want  [2];
    req_t       cur   [2];
    logic [1:0] tr    [2];
    int         win;
    req_t       e;
    tr[0] = M0_HTRANS; tr[1] = M1_HTRANS;
    cur[0] = '{M0_HADDR, M0_HSIZE, M0_HWRITE};
    cur[1] = '{M1_HADDR, M1_HSIZE, M1_HWRITE};
    for (int x = 0; x < 2; x++) begin
      e_rdy[x] = waiting[x] ? 1'b0 : ((dp_own == x) ? S_HREADYOUT : 1'b1);
      live[x]  = tr[x][1] && e_rdy[x];
      want[x]  = waiting[x] || live[x];
      if (waiting[x]) cur[x] = held[x];
    end
    win = -1;
    if (S_HREADYOUT && !HRESET) begin
      if (want[0] && want[1]) begin
`ifdef AHB_ARB_RR_EN
        win = (last_win == 0) ? 1 : 0;
`else
        win = 0;
`endif
      end else if (want[0]) win = 0;
      else if (want[1]) win = 1;
    end
    e = (win >= 0) ? cur[win] : '{M0_HADDR, M0_HSIZE, M0_HWRITE};
    chk("rnd_trans", 64'(S_HTRANS), (win >= 0) ? 64'(NS) : 64'(ID));
    chk("rnd_sel", 64'(S_HSEL), 64'(win >= 0));
    chk("rnd_addr", 64'(S_HADDR), 64'(e.addr));
    chk("rnd_size", 64'(S_HSIZE), 64'(e.size));
    chk("rnd_write", 64'(S_HWRITE), 64'(e.wr));
    chk("rnd_wdata", 64'(S_HWDATA), (dp_own == 1) ? 64'(M1_HWDATA) : 64'(M0_HWDATA));
    chk("rnd_rdy0", 64'(M0_HREADY), 64'(e_rdy[0]));
    chk("rnd_rdy1", 64'(M1_HREADY), 64'(e_rdy[1]));
    chk("rnd_resp0", 64'(M0_HRESP), (dp_own == 0) ? 64'(S_HRESP) : 64'd0);
    chk("rnd_resp1", 64'(M1_HRESP), (dp_own == 1) ? 64'(S_HRESP) : 64'd0);
    chk("rnd_rdata1", 64'(M1_HRDATA), 64'(S_HRDATA));
    chk("rnd_sready", 64'(S_HREADY), 64'(S_HREADYOUT));
    if (HRESET) begin
      model_reset();
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (win == x) waiting[x] = 1'b0;
        else if (live[x]) begin
          waiting[x] = 1'b1;
          held[x] = cur[x];
        end
        prev_rdy[x] = e_rdy[x];
      end
      if (S_HREADYOUT) begin
        dp_own = win;
        if (win >= 0) last_win = win;
      end
    end
  endtask

  // directed vectors
  typedef struct {
    logic [1:0] t0; logic [AW-1:0] a0; logic w0; logic [DW-1:0] d0;
    logic [1:0] t1; logic [AW-1:0] a1; logic w1; logic [DW-1:0] d1;
    logic rdy; logic resp; logic [DW-1:0] rdata;
    logic [1:0] e_trans; logic e_sel; logic [AW-1:0] e_addr; logic e_write; logic [DW-1:0] e_wdata;
    logic e_rdy0; logic e_rdy1; logic e_resp0; logic e_resp1; logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t tbl [11];

  task automatic run_vec(input int lo, input int hi);
    vec_t v;
    do_reset();
    for (int i = lo; i <= hi; i++) begin
      v = tbl[i];
      M0_HTRANS = v.t0; M0_HADDR = v.a0; M0_HWRITE = v.w0; M0_HWDATA = v.d0;
      M1_HTRANS = v.t1; M1_HADDR = v.a1; M1_HWRITE = v.w1; M1_HWDATA = v.d1;
      S_HREADYOUT = v.rdy; S_HRESP = v.resp; S_HRDATA = v.rdata;
      @(negedge HCLK);
      chk($sformatf("vec%0d_trans", i), 64'(S_HTRANS), 64'(v.e_trans));
      chk($sformatf("vec%0d_sel", i), 64'(S_HSEL), 64'(v.e_sel));
      chk($sformatf("vec%0d_addr", i), 64'(S_HADDR), 64'(v.e_addr));
      chk($sformatf("vec%0d_write", i), 64'(S_HWRITE), 64'(v.e_write));
      chk($sformatf("vec%0d_wdata", i), 64'(S_HWDATA), 64'(v.e_wdata));
      chk($sformatf("vec%0d_rdy0", i), 64'(M0_HREADY), 64'(v.e_rdy0));
      chk($sformatf("vec%0d_rdy1", i), 64'(M1_HREADY), 64'(v.e_rdy1));
      chk($sformatf("vec%0d_resp0", i), 64'(M0_HRESP), 64'(v.e_resp0));
      chk($sformatf("vec%0d_resp1", i), 64'(M1_HRESP), 64'(v.e_resp1));
      chk($sformatf("vec%0d_rdata0", i), 64'(M0_HRDATA), 64'(v.e_rdata));
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    logic [AW-1:0] rr_exp [4];
    tbl[0]  = '{NS, 17'h100, 1'b1, 32'h0, ID, 17'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
                NS, 1'b1, 17'h100, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{NS, 17'h100, 1'b0, 32'hDEADBEEF, ID, 17'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
                NS, 1'b1, 17'h100, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{ID, 17'h100, 1'b0, 32'h0, ID, 17'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF,
                ID, 1'b0, 17'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{NS, 17'h10, 1'b1, 32'h0, NS, 17'h20, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0,
                NS, 1'b1, 17'h10, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{ID, 17'h10, 1'b0, 32'hA0A0A0A0, ID, 17'h20, 1'b1, 32'hB1B1B1B1, 1'b1, 1'b0, 32'h0,
                NS, 1'b1, 17'h20, 1'b1, 32'hA0A0A0A0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{ID, 17'h10, 1'b0, 32'h0, ID, 17'h20, 1'b1, 32'hB1B1B1B1, 1'b1, 1'b0, 32'h0,
                ID, 1'b0, 17'h10, 1'b0, 32'hB1B1B1B1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{NS, 17'h40, 1'b0, 32'h0, ID, 17'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
                NS, 1'b1, 17'h40, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{ID, 17'h40, 1'b0, 32'h0, NS, 17'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                ID, 1'b0, 17'h40, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{ID, 17'h40, 1'b0, 32'h0, ID, 17'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                ID, 1'b0, 17'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{ID, 17'h40, 1'b0, 32'h0, ID, 17'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h12345678,
                NS, 1'b1, 17'h80, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678};
    tbl[10] = '{ID, 17'h40, 1'b0, 32'h0, ID, 17'h80, 1'b0, 32'h55, 1'b1, 1'b1, 32'h0,
                ID, 1'b0, 17'h40, 1'b0, 32'h55, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};

    idle_inputs();
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_trans", 64'(S_HTRANS), 64'(ID));
    chk("rst_sel", 64'(S_HSEL), 64'd0);
    chk("rst_rdy0", 64'(M0_HREADY), 64'd1);
    chk("rst_rdy1", 64'(M1_HREADY), 64'd1);
    chk("rst_resp1", 64'(M1_HRESP), 64'd0);
    @(posedge HCLK); #1;

    run_vec(0, 2);   // M0 alone: write then read
    run_vec(3, 5);   // simultaneous writes, M1 parked one cycle
    run_vec(6, 10);  // two wait states, then error response to M1

    // continuous contention from both masters
`ifdef AHB_ARB_RR_EN
    rr_exp = '{17'h10, 17'h20, 17'h10, 17'h20};
`else
    rr_exp = '{17'h10, 17'h10, 17'h10, 17'h10};
`endif
    do_reset();
    M0_HTRANS = NS; M0_HADDR = 17'h10; M0_HWRITE = 1'b1;
    M1_HTRANS = NS; M1_HADDR = 17'h20; M1_HWRITE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk($sformatf("arb%0d_trans", i), 64'(S_HTRANS), 64'(NS));
      chk($sformatf("arb%0d_addr", i), 64'(S_HADDR), 64'(rr_exp[i]));
      @(posedge HCLK); #1;
    end

    // reset while M1 is parked
    do_reset();
    M0_HTRANS = NS; M0_HADDR = 17'h40;
    M1_HTRANS = NS; M1_HADDR = 17'h80;
    @(posedge HCLK); #1;
    idle_inputs();
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rstpend_m1_parked", 64'(M1_HREADY), 64'd0);
    chk("rstpend_trans_in_rst", 64'(S_HTRANS), 64'(ID));
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      chk($sformatf("rstpend%0d_trans", i), 64'(S_HTRANS), 64'(ID));
      chk($sformatf("rstpend%0d_sel", i), 64'(S_HSEL), 64'd0);
      chk($sformatf("rstpend%0d_rdy1", i), 64'(M1_HREADY), 64'd1);
      @(posedge HCLK); #1;
    end

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      HRESET = ($urandom_range(0, 199) == 0);
      if (prev_rdy[0]) begin
        M0_HTRANS = 2'($urandom); M0_HADDR = AW'($urandom); M0_HSIZE = 3'($urandom);
        M0_HWRITE = 1'($urandom); M0_HWDATA = $urandom;
      end
      if (prev_rdy[1]) begin
        M1_HTRANS = 2'($urandom); M1_HADDR = AW'($urandom); M1_HSIZE = 3'($urandom);
        M1_HWRITE = 1'($urandom); M1_HWDATA = $urandom;
      end
      S_HREADYOUT = ($urandom_range(0, 3) != 0);
      S_HRESP = ($urandom_range(0, 7) == 0);
      S_HRDATA = $urandom;
      @(negedge HCLK);
      model_cycle();
      @(posedge HCLK); #1;
    end
    HRESET = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arb2.md
Name: ahb_lite_arb2

Overview:
- Two-master AHB-Lite arbiter that shares one AHB-Lite slave port, typically the BRAM SDP bridge, between the CPU (M0) and a DMA or debug master (M1).
- Each master sees a private AHB-Lite slave interface.
- Uncontended transfers pass through with zero added latency.
- A losing master's address phase is captured in a pending register, and that master is stalled via its HREADY until its transfer completes on the shared slave.

Parameters:
HADDR_WIDTH, 17, address width on all ports
HDATA_WIDTH, 32, data width on all ports

Ports:
HCLK  in  1  clock
HRESET  in  1  reset, synchronous, active-high
Mx_HADDR  in  HADDR_WIDTH  master x address (x=0,1; same for all Mx_ ports)
Mx_HTRANS  in  2  master x transfer type
Mx_HSIZE  in  3  master x size
Mx_HWRITE  in  1  master x write
Mx_HWDATA  in  HDATA_WIDTH  master x write data
Mx_HRDATA  out  HDATA_WIDTH  read data to master x
Mx_HREADY  out  1  ready to master x
Mx_HRESP  out  1  response to master x
S_HADDR  out  HADDR_WIDTH  slave address
S_HTRANS  out  2  slave transfer type
S_HSIZE  out  3  slave size
S_HWRITE  out  1  slave write
S_HWDATA  out  HDATA_WIDTH  slave write data
S_HSEL  out  1  slave select
S_HREADY  out  1  bus ready to slave, equal to S_HREADYOUT
S_HRDATA  in  HDATA_WIDTH  slave read data
S_HREADYOUT  in  1  slave ready
S_HRESP  in  1  slave response

Behaviour:
- Per-master request sources:
  - live: Mx_HTRANS is NONSEQ or SEQ while Mx_HREADY=1.
  - pend_x: registered address, size, write and a valid bit.
  - Candidate x is pend_x when its valid bit is set, else live x.
- Grant is evaluated only when S_HREADYOUT=1. With S_HREADYOUT=0, no grant is made.
- Granted candidate drives S_HADDR/S_HSIZE/S_HWRITE, with S_HTRANS=NONSEQ (SEQ is always converted) and S_HSEL=1.
- No grant: S_HTRANS=IDLE, S_HSEL=0, other S_ address/control outputs hold the M0 live values.
- A live request that is not granted in its accept cycle is captured into pend_x at the clock edge. pend_x clears at the edge where it is granted.
- Data-phase tracking:
  - dp_valid and dp_owner are set at the edge when S_HREADYOUT=1 and a grant occurred.
  - dp_valid is cleared at an S_HREADYOUT=1 edge with no grant.
- S_HWDATA = HWDATA of dp_owner (M0 when dp_valid=0).
- Mx_HREADY:
  - 0 while pend_x is valid.
  - S_HREADYOUT while dp_valid and dp_owner=x.
  - 1 otherwise.
- Mx_HRESP = S_HRESP when dp_valid and dp_owner=x, else 0.
- Mx_HRDATA = S_HRDATA for both masters.
- Arbitration:
  - Fixed priority, M0 wins; see Optional Feature for round-robin.
  - A single pending master always wins over an idle opponent.
- A master has at most one pend entry. Its next live request can only appear after its HREADY returns to 1.
- Latency:
  - Uncontended: same as direct slave connection.
  - Loser: one extra data-phase cycle per winner transfer ahead of it, with a zero-wait slave.
- Slave wait states (S_HREADYOUT=0): both masters' new live requests are captured into pend_x and issued in priority order afterwards.
- Reset (HRESET=1 at an edge):
  - pend_x valid=0, dp_valid=0, rr_last=M1 (M0 first).
  - Outputs after reset: Mx_HREADY=1, Mx_HRESP=0, S_HTRANS=IDLE, S_HSEL=0.
- Reset mid-transfer: pending and in-flight transfers are dropped. No slave transfer is issued in the cycle after reset deasserts unless a new live request appears.

Optional Feature:
- Macro AHB_ARB_RR_EN.
- Defined: round-robin.
  - rr_last records the last granted master.
  - When both candidates request, the master not equal to rr_last wins.
  - rr_last updates on every grant.
- Undefined: fixed priority, M0 always wins. rr_last logic is not built.

Test Plan:
- M0 alone, zero-wait slave: writes 0xDEADBEEF to 0x100, then reads 0x100 -> S_HTRANS/S_HADDR match M0 in the same cycle, M0_HREADY stays 1, M0_HRDATA=0xDEADBEEF, M1_HREADY=1.
- Both masters issue a NONSEQ write in the same cycle (M0 to 0x10, M1 to 0x20):
  - 0x10 issued first, M1 captured into pend.
  - M1_HREADY=0 for one cycle, 0x20 issued the next cycle.
  - S_HWDATA switches from M0 to M1 data accordingly.
- Round-robin build (AHB_ARB_RR_EN defined), both masters request back-to-back for 4 cycles -> grants alternate M0,M1,M0,M1. In the non-RR build, every contended grant goes to M0.
- Slave inserts 2 wait states on M0's read while M1 issues a request -> M1 captured into pend, M1_HREADY=0 throughout, M1 issued on the first S_HREADYOUT=1 cycle.
- S_HRESP=1 on M1's data phase -> M1_HRESP=1, M0_HRESP=0.
- HRESET asserted while M1 is pending -> next cycle S_HTRANS=IDLE, M1_HREADY=1, no M1 transfer reaches the slave.
